// File: rtl/intc_pkg.sv
// Shared definitions for the interrupt controller: CSR map, FSM states and CTRL layout.
package intc_pkg;

    localparam int unsigned CSR_AW   = 5;
    localparam int unsigned CSR_DW   = 8;
    localparam int unsigned HOLD_W   = 4;
    localparam int unsigned NUM_REGS = 5;

    localparam logic [CSR_AW-1:0] OFS_EN   = 5'd0;
    localparam logic [CSR_AW-1:0] OFS_PEND = 5'd1;
    localparam logic [CSR_AW-1:0] OFS_EDGE = 5'd2;
    localparam logic [CSR_AW-1:0] OFS_RAW  = 5'd3;
    localparam logic [CSR_AW-1:0] OFS_CTRL = 5'd4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ASSERT  = 2'd1,
        ST_HOLDOFF = 2'd2
    } intc_state_e;

    // CTRL register image; rsvd is held at zero so the struct reads back directly.
    typedef struct packed {
        logic [HOLD_W-1:0] hold;
        logic [2:0]        rsvd;
        logic              gen;
    } intc_ctrl_t;

    localparam logic [CSR_DW-1:0] CTRL_RST = 8'h01;

    function automatic intc_ctrl_t ctrl_from_bus(input logic [CSR_DW-1:0] d);
        intc_ctrl_t c;
        c.hold = d[7:4];
        c.rsvd = 3'b000;
        c.gen  = d[0];
        return c;
    endfunction

endpackage

// File: rtl/intc_pend_cell.sv
// One interrupt source: edge-delay flop plus pending flop where a set beats a W1C clear.
module intc_pend_cell (
    input  logic clk,
    input  logic rst_n,
    input  logic i_src,
    input  logic i_edge,
    input  logic i_clr,
    output logic o_pend
);

    logic r_dly;
    logic r_pend;
    logic w_set;

    assign w_set = i_edge ? (i_src & ~r_dly) : i_src;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dly  <= 1'b0;
            r_pend <= 1'b0;
        end else begin
            r_dly  <= i_src;
            r_pend <= w_set | (r_pend & ~i_clr);
        end
    end

    assign o_pend = r_pend;

endmodule

// File: rtl/intc.sv
// Interrupt controller: per-source pending/enable/edge CSRs and an irq_out sequencer
// that inserts a holdoff gap so an edge-sensitive host sees a new edge after each ack.
module intc #(
    parameter logic [4:0]  BASE_ADDR = 5'h18,
    parameter int unsigned NUM_SRC   = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               tick_ce,
    input  logic [4:0]         csr_a,
    input  logic [7:0]         csr_di,
    input  logic               csr_we,
    output logic [7:0]         csr_do,
    input  logic [NUM_SRC-1:0] irq_src,
    output logic               irq_out
);

    import intc_pkg::*;

    logic [NUM_SRC-1:0] r_en;
    logic [NUM_SRC-1:0] r_edge;
    intc_ctrl_t         r_ctrl;
    logic               r_w1c;
    logic [CSR_DW-1:0]  r_do;
    logic               r_irq;
    intc_state_e        r_state;
    logic [HOLD_W-1:0]  r_cnt;

    logic               w_in_rng;
    logic [CSR_AW-1:0]  w_ofs;
    logic               w_wr;
    logic [NUM_SRC-1:0] w_clr;
    logic [NUM_SRC-1:0] w_pend;
    logic               w_active;
    logic [CSR_DW-1:0]  w_rd;
    intc_state_e        w_state_nxt;
    logic [HOLD_W-1:0]  w_cnt_nxt;

    // Address decode over the block's window.
    assign w_in_rng = ({1'b0, csr_a} >= 6'(BASE_ADDR)) &&
                      ({1'b0, csr_a} <  (6'(BASE_ADDR) + 6'(NUM_REGS)));
    assign w_ofs    = csr_a - BASE_ADDR;
    assign w_wr     = csr_we && w_in_rng;
    assign w_clr    = (w_wr && (w_ofs == OFS_PEND)) ? csr_di[NUM_SRC-1:0] : '0;

    for (genvar g = 0; g < int'(NUM_SRC); g++) begin : g_src
        intc_pend_cell u_cell (
            .clk    (clk),
            .rst_n  (rst_n),
            .i_src  (irq_src[g]),
            .i_edge (r_edge[g]),
            .i_clr  (w_clr[g]),
            .o_pend (w_pend[g])
        );
    end

    assign w_active = r_ctrl.gen & (|(w_pend & r_en));

    // Configuration registers; r_w1c remembers an effective ack for the retrigger path.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_en   <= '0;
            r_edge <= '0;
            r_ctrl <= ctrl_from_bus(CTRL_RST);
            r_w1c  <= 1'b0;
        end else begin
            r_w1c <= |w_clr;
            if (w_wr) begin
                case (w_ofs)
                    OFS_EN:   r_en   <= csr_di[NUM_SRC-1:0];
                    OFS_EDGE: r_edge <= csr_di[NUM_SRC-1:0];
                    OFS_CTRL: r_ctrl <= ctrl_from_bus(csr_di);
                    default:  ;
                endcase
            end
        end
    end

    always_comb begin
        w_rd = '0;
        if (w_in_rng) begin
            case (w_ofs)
                OFS_EN:   w_rd = CSR_DW'(r_en);
                OFS_PEND: w_rd = CSR_DW'(w_pend);
                OFS_EDGE: w_rd = CSR_DW'(r_edge);
                OFS_RAW:  w_rd = CSR_DW'(irq_src);
                OFS_CTRL: w_rd = r_ctrl;
                default:  w_rd = '0;
            endcase
        end
    end

    // Sequencer next-state: ASSERT drops to HOLDOFF on an ack or on loss of active.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_active) begin
                    w_state_nxt = ST_ASSERT;
                end
            end
            ST_ASSERT: begin
                if (!w_active) begin
                    if (r_ctrl.hold == '0) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_state_nxt = ST_HOLDOFF;
                        w_cnt_nxt   = r_ctrl.hold;
                    end
                end else if (r_w1c) begin
                    w_state_nxt = ST_HOLDOFF;
                    w_cnt_nxt   = r_ctrl.hold;
                end
            end
            ST_HOLDOFF: begin
                if (r_cnt == '0) begin
                    w_state_nxt = ST_IDLE;
                end else if (tick_ce) begin
                    w_cnt_nxt = r_cnt - HOLD_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_irq   <= 1'b0;
            r_do    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_irq   <= (w_state_nxt == ST_ASSERT);
            r_do    <= w_rd;
        end
    end

    assign csr_do  = r_do;
    assign irq_out = r_irq;

endmodule

// File: tb/tb_intc.sv
// Directed bench for intc: expected values queued at stimulus time, popped at sample time.
module tb_intc;

    logic       clk;
    logic       rst_n;
    logic       tick_ce;
    logic [4:0] csr_a;
    logic [7:0] csr_di;
    logic       csr_we;
    logic [7:0] csr_do;
    logic [7:0] irq_src;
    logic       irq_out;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] sb_exp[$];
    string      sb_tag[$];

    localparam logic [4:0] A_EN   = 5'h18;
    localparam logic [4:0] A_PEND = 5'h19;
    localparam logic [4:0] A_EDGE = 5'h1A;
    localparam logic [4:0] A_RAW  = 5'h1B;
    localparam logic [4:0] A_CTRL = 5'h1C;

    intc #(.BASE_ADDR(5'h18), .NUM_SRC(8)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .tick_ce (tick_ce),
        .csr_a   (csr_a),
        .csr_di  (csr_di),
        .csr_we  (csr_we),
        .csr_do  (csr_do),
        .irq_src (irq_src),
        .irq_out (irq_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic push(input string t, input logic [7:0] e);
        sb_exp.push_back(e);
        sb_tag.push_back(t);
    endtask

    task automatic pop_cmp(input logic [7:0] obs);
        logic [7:0] e;
        string      t;
        n_tests++;
        if (sb_exp.size() == 0) begin
            n_fail++;
            $display("FAIL scoreboard_empty: observed %h with nothing expected", obs);
        end else begin
            e = sb_exp.pop_front();
            t = sb_tag.pop_front();
            assert (obs === e) else begin
                n_fail++;
                $error("FAIL %s: observed %h expected %h", t, obs, e);
            end
        end
    endtask

    task automatic wr(input logic [4:0] a, input logic [7:0] d);
        csr_a  = a;
        csr_di = d;
        csr_we = 1'b1;
        @(negedge clk);
        csr_we = 1'b0;
        csr_di = 8'h00;
    endtask

    task automatic rd(input logic [4:0] a, input logic [7:0] e, input string t);
        csr_a  = a;
        csr_we = 1'b0;
        push(t, e);
        @(negedge clk);
        pop_cmp(csr_do);
    endtask

    task automatic chk_irq(input logic e, input string t);
        push(t, {7'b0, e});
        pop_cmp({7'b0, irq_out});
    endtask

    task automatic wait_irq(input logic v, input int n, input string t);
        for (int i = 0; i < n; i++) begin
            if (irq_out === v) break;
            @(negedge clk);
        end
        chk_irq(v, t);
    endtask

    int ticks;

    initial begin
        rst_n   = 1'b0;
        tick_ce = 1'b0;
        csr_a   = 5'h00;
        csr_di  = 8'h00;
        csr_we  = 1'b0;
        irq_src = 8'h00;
        repeat (3) @(negedge clk);
        chk_irq(1'b0, "rst_irq_held");
        rst_n = 1'b1;
        @(negedge clk);

        // Reset defaults and address window
        chk_irq(1'b0, "rst_irq");
        rd(A_EN,   8'h00, "rst_en");
        rd(A_PEND, 8'h00, "rst_pend");
        rd(A_EDGE, 8'h00, "rst_edge");
        rd(A_CTRL, 8'h01, "rst_ctrl");
        rd(5'h05,  8'h00, "out_of_range_low");
        rd(5'h1D,  8'h00, "out_of_range_high");

        // RAW follows the inputs; writes to it are ignored
        irq_src = 8'hA5;
        wr(A_RAW, 8'h00);
        rd(A_RAW, 8'hA5, "raw_read");
        irq_src = 8'h00;
        @(negedge clk);
        wr(A_PEND, 8'hFF);
        rd(A_PEND, 8'h00, "raw_pend_cleared");
        chk_irq(1'b0, "raw_irq_masked");

        // Level source: two-cycle latency, retrigger on ack while still high
        wr(A_EN, 8'h01);
        irq_src = 8'h01;
        @(negedge clk);
        chk_irq(1'b0, "lvl_lat1");
        @(negedge clk);
        chk_irq(1'b1, "lvl_lat2");
        wr(A_PEND, 8'h01);
        @(negedge clk);
        chk_irq(1'b0, "lvl_retrig_low");
        rd(A_PEND, 8'h01, "lvl_pend_reset");
        wait_irq(1'b1, 6, "lvl_retrig_high");
        irq_src = 8'h00;
        @(negedge clk);
        wr(A_PEND, 8'h01);
        @(negedge clk);
        chk_irq(1'b0, "lvl_clear_irq");
        rd(A_PEND, 8'h00, "lvl_pend_clr");
        repeat (2) @(negedge clk);
        chk_irq(1'b0, "lvl_idle");

        // Edge source latched while masked, then unmasked
        wr(A_EN, 8'h00);
        wr(A_EDGE, 8'h02);
        irq_src = 8'h02;
        @(negedge clk);
        irq_src = 8'h00;
        rd(A_PEND, 8'h02, "edge_pend");
        chk_irq(1'b0, "edge_masked");
        wr(A_EN, 8'h02);
        @(negedge clk);
        chk_irq(1'b1, "edge_unmask");
        wr(A_PEND, 8'h02);
        @(negedge clk);
        chk_irq(1'b0, "edge_clr");

        // Set beats W1C in the same cycle
        wr(A_EDGE, 8'h06);
        irq_src = 8'h04;
        wr(A_PEND, 8'h04);
        irq_src = 8'h00;
        rd(A_PEND, 8'h04, "coll_set_wins");
        wr(A_PEND, 8'h04);
        rd(A_PEND, 8'h00, "coll_clear");

        // Holdoff of 3 tick periods after acking one of two pending sources
        wr(A_CTRL, 8'h31);
        wr(A_EN, 8'h06);
        irq_src = 8'h06;
        @(negedge clk);
        irq_src = 8'h00;
        wait_irq(1'b1, 4, "hold_assert");
        wr(A_PEND, 8'h02);
        @(negedge clk);
        chk_irq(1'b0, "hold_low");
        ticks = 0;
        for (int c = 0; c < 40 && irq_out !== 1'b1; c++) begin
            tick_ce = ((c % 4) == 3);
            if (tick_ce) ticks++;
            @(negedge clk);
            tick_ce = 1'b0;
        end
        chk_irq(1'b1, "hold_rehigh");
        push("hold_ticks_3to4", 8'h01);
        pop_cmp({7'b0, (ticks >= 3 && ticks <= 4)});

        // Reset in the middle of a holdoff
        irq_src = 8'h02;
        @(negedge clk);
        irq_src = 8'h00;
        wr(A_PEND, 8'h02);
        @(negedge clk);
        chk_irq(1'b0, "hold2_low");
        rd(A_PEND, 8'h04, "hold2_pend");
        rst_n = 1'b0;
        #1;
        chk_irq(1'b0, "rst_mid_irq");
        @(negedge clk);
        rst_n = 1'b1;
        rd(A_CTRL, 8'h01, "rst_mid_ctrl");
        rd(A_PEND, 8'h00, "rst_mid_pend");
        rd(A_EN,   8'h00, "rst_mid_en");
        chk_irq(1'b0, "rst_mid_irq_after");

        // Global enable off and back on
        wr(A_EN, 8'h01);
        irq_src = 8'h01;
        wait_irq(1'b1, 5, "gen_assert");
        wr(A_CTRL, 8'h00);
        @(negedge clk);
        chk_irq(1'b0, "gen_off");
        @(negedge clk);
        chk_irq(1'b0, "gen_off_stay");
        rd(A_PEND, 8'h01, "gen_pend_kept");
        rd(A_CTRL, 8'h00, "gen_ctrl_rd");
        wr(A_CTRL, 8'h01);
        @(negedge clk);
        chk_irq(1'b1, "gen_on");
        irq_src = 8'h00;

        if (sb_exp.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard_leftover: %0d expected entries not consumed", sb_exp.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
